// File: rtl/qpi_line_burst.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : qpi_line_burst
// Purpose  : Cache-line transfer engine feeding the QPI-to-SDRAM adapter.
//            Accepts one whole-line fill (read) or writeback (write) request,
//            runs a LINE_WORDS-word burst on the QPI interface, assembles
//            fill words into a line register and pulses done once the
//            adapter has gone idle again.
// Ports    : clk, rst (sync, active-low)
//            req_valid/req_ready/req_write/req_addr/req_wline : line request
//            rd_line  : assembled fill line (valid on done)
//            done     : one-cycle completion pulse
//            qpi_do_read/qpi_do_write/qpi_addr/qpi_wdata     : to adapter
//            qpi_rdata/qpi_next_word/qpi_is_idle              : from adapter
// Revision : 1.0 - initial release
// ============================================================================
module qpi_line_burst #(
  parameter int LINE_WORDS = 8,
  parameter int CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [24:0]             req_addr,
  input  logic [32*LINE_WORDS-1:0] req_wline,
  output logic [32*LINE_WORDS-1:0] rd_line,
  output logic                    done,
  output logic                    qpi_do_read,
  output logic                    qpi_do_write,
  output logic [24:0]             qpi_addr,
  output logic [31:0]             qpi_wdata,
  input  logic [31:0]             qpi_rdata,
  input  logic                    qpi_next_word,
  input  logic                    qpi_is_idle
);

  localparam int IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  // Byte-offset bits inside a line: word index plus 2 byte-select bits.
  localparam int LOW_W = IDX_W + 2;
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      r_write;
  logic [24:0]               r_base;
  logic [CNT_W-1:0]          r_cnt;
  logic [32*LINE_WORDS-1:0]  r_wline;
  logic [32*LINE_WORDS-1:0]  r_rd_line;
  logic                      w_accept;
  logic                      w_ready;
  logic [IDX_W-1:0]          w_idx;
  logic                      w_unused;

  // Line-offset address bits are discarded; the burst always starts aligned.
  assign w_unused = ^req_addr[LOW_W-1:0];

  assign w_idx = r_cnt[IDX_W-1:0];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded outputs. do_read/do_write depend only on
  // r_state and r_write so they cannot glitch with qpi_next_word.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next       = r_state;
    w_ready      = 1'b0;
    w_accept     = 1'b0;
    qpi_do_read  = 1'b0;
    qpi_do_write = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Held low while in reset so nothing upstream sees a false ready.
        w_ready  = qpi_is_idle & rst;
        w_accept = req_valid & w_ready;
        if (w_accept) begin
          w_next = S_BURST;
        end
      end
      S_BURST: begin
        qpi_do_write = r_write;
        qpi_do_read  = ~r_write;
        // Leaving on the last ack drops do_* next cycle, which the adapter
        // takes as the end-of-burst indication.
        if (qpi_next_word && (r_cnt == C_LAST_CNT)) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (qpi_is_idle) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign req_ready = w_ready;

  // --------------------------------------------------------------------------
  // Datapath: request latch, word counter and fill-line assembly.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_write   <= 1'b0;
      r_base    <= '0;
      r_cnt     <= '0;
      r_wline   <= '0;
      r_rd_line <= '0;
    end else begin
      if (w_accept) begin
        r_base  <= {req_addr[24:LOW_W], {LOW_W{1'b0}}};
        r_write <= req_write;
        r_wline <= req_wline;
        r_cnt   <= '0;
      end else if ((r_state == S_BURST) && qpi_next_word) begin
        if (!r_write) begin
          r_rd_line[{w_idx, 5'd0} +: 32] <= qpi_rdata;
        end
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign qpi_addr  = r_base;
  assign qpi_wdata = (r_state == S_BURST) ? r_wline[{w_idx, 5'd0} +: 32] : 32'd0;
  assign rd_line   = r_rd_line;

endmodule
`default_nettype wire
